// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: data/address widths and the
// arbiter state encoding.
package data_mem_arbiter_pkg;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned DATA_ADDR_BITS = 8;

  typedef logic [DATA_BITS-1:0]      data_t;
  typedef logic [DATA_ADDR_BITS-1:0] data_memory_address_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_READ_WAIT,
    ARB_WRITE_WAIT,
    ARB_RELEASE
  } arb_state_t;

  // Width of an index into n channels; never narrower than one bit.
  function automatic int unsigned index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_select.sv
// Combinational request picker: returns the first set request found when
// scanning upward from start_index, wrapping past the top channel to 0.
module arb_priority_select
  import data_mem_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQUESTS = 4,
  localparam int unsigned IDX_W        = index_width(NUM_REQUESTS)
) (
  input  logic [NUM_REQUESTS-1:0] request,
  input  logic [IDX_W-1:0]        start_index,
  output logic                    found,
  output logic [IDX_W-1:0]        index
);

  // One extra bit so start_index + offset cannot overflow before the wrap.
  logic [IDX_W:0] cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQUESTS; i++) begin
      cand = {1'b0, start_index} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQUESTS)) begin
        cand = cand - (IDX_W+1)'(NUM_REQUESTS);
      end
      if (!found && request[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port among NUM_CONSUMERS LSU channels, one
// transaction at a time. Define DATA_MEM_ARB_ROUND_ROBIN_EN for round-robin
// grant; otherwise the lowest requesting index always wins.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = 4
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic [NUM_CONSUMERS-1:0]   consumer_read_valid,
  input  data_memory_address_t       consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]   consumer_read_ready,
  output data_t                      consumer_read_data [NUM_CONSUMERS],

  input  logic [NUM_CONSUMERS-1:0]   consumer_write_valid,
  input  data_memory_address_t       consumer_write_address [NUM_CONSUMERS],
  input  data_t                      consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]   consumer_write_ready,

  output logic                       mem_read_valid,
  output data_memory_address_t       mem_read_address,
  input  logic                       mem_read_ready,
  input  data_t                      mem_read_data,

  output logic                       mem_write_valid,
  output data_memory_address_t       mem_write_address,
  output data_t                      mem_write_data,
  input  logic                       mem_write_ready
);

  localparam int unsigned IDX_W = index_width(NUM_CONSUMERS);
  typedef logic [IDX_W-1:0] idx_t;

  arb_state_t               state, state_next;
  idx_t                     grant;
  idx_t                     sel_index;
  idx_t                     start_index;
  logic                     sel_found;
  logic                     serving_read;
  logic                     served_valid;
  logic                     read_done;
  logic                     write_done;
  logic [NUM_CONSUMERS-1:0] eligible;
  data_t                    read_data_q [NUM_CONSUMERS];

  assign eligible     = consumer_read_valid | consumer_write_valid;
  assign read_done    = (state == ARB_READ_WAIT)  && mem_read_ready;
  assign write_done   = (state == ARB_WRITE_WAIT) && mem_write_ready;
  assign served_valid = serving_read ? consumer_read_valid[grant]
                                     : consumer_write_valid[grant];

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  idx_t priority_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      priority_ptr <= '0;
    end else if (read_done || write_done) begin
      priority_ptr <= (grant == idx_t'(NUM_CONSUMERS - 1)) ? '0 : grant + idx_t'(1);
    end
  end

  assign start_index = priority_ptr;
`else
  assign start_index = '0;
`endif

  arb_priority_select #(
    .NUM_REQUESTS (NUM_CONSUMERS)
  ) u_select (
    .request     (eligible),
    .start_index (start_index),
    .found       (sel_found),
    .index       (sel_index)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE: begin
        if (sel_found) begin
          state_next = consumer_read_valid[sel_index] ? ARB_READ_WAIT : ARB_WRITE_WAIT;
        end
      end
      ARB_READ_WAIT:  if (mem_read_ready)  state_next = ARB_RELEASE;
      ARB_WRITE_WAIT: if (mem_write_ready) state_next = ARB_RELEASE;
      ARB_RELEASE:    if (!served_valid)   state_next = ARB_IDLE;
      default:        state_next = ARB_IDLE;
    endcase
  end

  // Request fields are captured only on the grant edge; a read wins over a
  // write from the same consumer, leaving the write pending for a later grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant             <= '0;
      serving_read      <= 1'b0;
      mem_read_address  <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
        read_data_q[i] <= '0;
      end
    end else begin
      if (state == ARB_IDLE && sel_found) begin
        grant        <= sel_index;
        serving_read <= consumer_read_valid[sel_index];
        if (consumer_read_valid[sel_index]) begin
          mem_read_address <= consumer_read_address[sel_index];
        end else begin
          mem_write_address <= consumer_write_address[sel_index];
          mem_write_data    <= consumer_write_data[sel_index];
        end
      end
      if (read_done) begin
        read_data_q[grant] <= mem_read_data;
      end
    end
  end

  // The completion pulse coincides with the memory handshake, so the load
  // result is forwarded in that cycle and held from the register afterwards.
  always_comb begin
    mem_read_valid       = (state == ARB_READ_WAIT);
    mem_write_valid      = (state == ARB_WRITE_WAIT);
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      consumer_read_data[i] = read_data_q[i];
    end
    if (read_done && !reset) begin
      consumer_read_ready[grant] = 1'b1;
      consumer_read_data[grant]  = mem_read_data;
    end
    if (write_done && !reset) begin
      consumer_write_ready[grant] = 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: single read/write, read-over-write,
// contention order, held-valid single service and mid-transaction reset.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int unsigned N = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         rd_valid, wr_valid, rd_ready, wr_ready;
  data_memory_address_t rd_addr [N];
  data_memory_address_t wr_addr [N];
  data_t                wr_data [N];
  data_t                rd_data [N];
  logic                 mem_read_valid, mem_write_valid, mem_read_ready, mem_write_ready;
  data_memory_address_t mem_read_address, mem_write_address;
  data_t                mem_read_data, mem_write_data;

  int vectors = 0;
  int miscompares = 0;
  int rd_pulses = 0, wr_pulses = 0, rd_xfers = 0, wr_xfers = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.NUM_CONSUMERS(N)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rd_valid),
    .consumer_read_address  (rd_addr),
    .consumer_read_ready    (rd_ready),
    .consumer_read_data     (rd_data),
    .consumer_write_valid   (wr_valid),
    .consumer_write_address (wr_addr),
    .consumer_write_data    (wr_data),
    .consumer_write_ready   (wr_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  always @(posedge clk) begin
    if (!reset) begin
      rd_pulses += $countones(rd_ready);
      wr_pulses += $countones(wr_ready);
      if (mem_read_valid && mem_read_ready)   rd_xfers++;
      if (mem_write_valid && mem_write_ready) wr_xfers++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a read grant, completes it, then withdraws consumer c.
  task automatic serve_read(input int c, input data_memory_address_t exp_addr, input data_t d);
    int waited = 0;
    while (!mem_read_valid && waited < 20) begin
      tick();
      waited++;
    end
    check("rr_grant_valid", mem_read_valid, 1);
    check("rr_grant_addr", mem_read_address, exp_addr);
    mem_read_ready = 1'b1;
    mem_read_data  = d;
    #1;
    check("rr_pulse", rd_ready, 32'(1) << c);
    check("rr_data", rd_data[c], d);
    tick();
    mem_read_ready = 1'b0;
    rd_valid[c]    = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    rd_valid = '0; wr_valid = '0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    for (int i = 0; i < N; i++) begin
      rd_addr[i] = 8'h40 + 8'(i);
      wr_addr[i] = '0;
      wr_data[i] = '0;
    end
    tick(2);
    check("reset_mem_read_valid", mem_read_valid, 0);
    check("reset_mem_write_valid", mem_write_valid, 0);
    check("reset_rd_ready", rd_ready, 0);
    check("reset_rd_data0", rd_data[0], 0);
    reset = 1'b0;
    tick();

    // single read on consumer 2, valid held two cycles past completion
    rd_pulses = 0; rd_xfers = 0;
    rd_valid[2] = 1'b1; rd_addr[2] = 8'h10;
    tick();
    check("rd_valid_after_grant", mem_read_valid, 1);
    check("rd_addr", mem_read_address, 8'h10);
    check("rd_no_early_pulse", rd_ready, 0);
    rd_addr[2] = 8'h99;
    tick(2);
    check("rd_valid_held", mem_read_valid, 1);
    check("rd_addr_sampled_at_grant", mem_read_address, 8'h10);
    mem_read_ready = 1'b1; mem_read_data = 8'hAB;
    #1;
    check("rd_pulse", rd_ready, 4'b0100);
    check("rd_data2", rd_data[2], 8'hAB);
    check("rd_no_write", mem_write_valid, 0);
    tick();
    mem_read_ready = 1'b0;
    #1;
    check("rd_valid_dropped", mem_read_valid, 0);
    check("rd_release_ready", rd_ready, 0);
    check("rd_data2_held", rd_data[2], 8'hAB);
    tick(2);
    check("rd_hold_no_regrant", mem_read_valid, 0);
    check("rd_hold_no_pulse", rd_ready, 0);
    rd_valid[2] = 1'b0; rd_addr[2] = 8'h42;
    tick(2);
    check("rd_pulse_count", rd_pulses, 1);
    check("rd_xfer_count", rd_xfers, 1);

    // single write on consumer 1
    wr_pulses = 0; wr_xfers = 0; rd_xfers = 0;
    wr_valid[1] = 1'b1; wr_addr[1] = 8'h20; wr_data[1] = 8'h55;
    tick();
    check("wr_valid", mem_write_valid, 1);
    check("wr_addr", mem_write_address, 8'h20);
    check("wr_data", mem_write_data, 8'h55);
    check("wr_no_read", mem_read_valid, 0);
    tick();
    check("wr_valid_held", mem_write_valid, 1);
    mem_write_ready = 1'b1;
    #1;
    check("wr_pulse", wr_ready, 4'b0010);
    check("wr_no_rd_pulse", rd_ready, 0);
    tick();
    mem_write_ready = 1'b0; wr_valid[1] = 1'b0;
    #1;
    check("wr_valid_dropped", mem_write_valid, 0);
    tick();
    check("wr_pulse_count", wr_pulses, 1);
    check("wr_xfer_count", wr_xfers, 1);
    check("wr_no_rd_xfer", rd_xfers, 0);

    // consumer 3 with read and write both pending: read first, write after
    rd_valid[3] = 1'b1; rd_addr[3] = 8'h30;
    wr_valid[3] = 1'b1; wr_addr[3] = 8'h31; wr_data[3] = 8'h77;
    tick();
    check("rw_read_first", mem_read_valid, 1);
    check("rw_write_pending", mem_write_valid, 0);
    check("rw_read_addr", mem_read_address, 8'h30);
    mem_read_ready = 1'b1; mem_read_data = 8'h3C;
    #1;
    check("rw_rd_pulse", rd_ready, 4'b1000);
    check("rw_no_wr_pulse", wr_ready, 0);
    tick();
    mem_read_ready = 1'b0; rd_valid[3] = 1'b0; rd_addr[3] = 8'h43;
    tick(2);
    check("rw_write_served", mem_write_valid, 1);
    check("rw_write_addr", mem_write_address, 8'h31);
    check("rw_write_data", mem_write_data, 8'h77);
    mem_write_ready = 1'b1;
    #1;
    check("rw_wr_pulse", wr_ready, 4'b1000);
    tick();
    mem_write_ready = 1'b0; wr_valid[3] = 1'b0;
    tick();

    // all four read at once; each withdraws once served
    rd_valid = 4'b1111;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    serve_read(0, 8'h40, 8'hC0);
    rd_valid[0] = 1'b1;
    serve_read(1, 8'h41, 8'hC1);
    serve_read(2, 8'h42, 8'hC2);
    serve_read(3, 8'h43, 8'hC3);
    serve_read(0, 8'h40, 8'hC4);
`else
    for (int i = 0; i < N; i++) serve_read(i, 8'h40 + 8'(i), 8'hC0 + 8'(i));

    // fixed priority: consumer 1 keeps re-requesting and starves consumer 3
    rd_valid[1] = 1'b1; rd_valid[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      serve_read(1, 8'h41, 8'hD0 + 8'(k));
      if (k < 2) rd_valid[1] = 1'b1;
    end
    serve_read(3, 8'h43, 8'hD3);
`endif

    // reset while a read is outstanding, then a late memory ready
    rd_xfers = 0; rd_pulses = 0;
    rd_valid[0] = 1'b1; rd_addr[0] = 8'h50;
    tick();
    check("rst_pre_valid", mem_read_valid, 1);
    reset = 1'b1; rd_valid[0] = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_read_valid", mem_read_valid, 0);
    check("rst_write_valid", mem_write_valid, 0);
    check("rst_read_addr", mem_read_address, 0);
    check("rst_rd_data2", rd_data[2], 0);
    check("rst_rd_ready", rd_ready, 0);
    mem_read_ready = 1'b1; mem_read_data = 8'hEE;
    #1;
    check("rst_late_ready_pulse", rd_ready, 0);
    check("rst_late_ready_data", rd_data[0], 0);
    tick();
    mem_read_ready = 1'b0;
    check("rst_stays_idle", mem_read_valid, 0);
    check("rst_no_xfer", rd_xfers, 0);
    check("rst_no_pulse", rd_pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
